multicycle_controller: RTL and testbench

Multi-cycle control FSM for the FRiscV CPU, replacing the single-cycle combinational controller so that instruction memory, data memory and the ALU can be shared across cycles. It decodes opcode/func3/func7 and sequences the datapath through fetch, decode, execute, memory and writeback states. It also adds a request/ready memory handshake with a bounded wait, illegal-instruction flagging and a full RV32I ALU-op decode. ALU operation codes and opcode symbols come from friscv_pkg.

---
 rtl/multicycle_controller.sv | 264 ++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// friscv_pkg + multicycle_controller
//
// Multi-cycle control FSM for the FRiscV CPU. It sequences the shared datapath
// through fetch, decode, execute, memory and writeback states. It also provides:
//   - a request/ready memory handshake with a bounded wait,
//   - flagging of illegal instructions,
//   - full RV32I ALU-operation decode.
//
// Ports:
//   clk_in            rising-edge clock
//   rst_in            asynchronous active-high reset
//   op_code_in        opcode from IR
//   func3_in          func3 from IR
//   func7_in          func7 from IR
//   zero_in           ALU zero flag (branch decision)
//   mem_ready_in      memory accepted/completed the current request
//   mem_req_out       memory request
//   mem_write_out     request is a write
//   adr_src_out       memory address select: 0 = PC, 1 = ALUOut
//   ir_write_out      load IR and oldPC
//   pc_write_out      load PC from result bus
//   reg_write_out     register-file write enable
//   alu_src_a_out     ALU A select: 00 PC, 01 oldPC, 10 rs1
//   alu_src_b_out     ALU B select: 00 rs2, 01 imm, 10 constant 4
//   alu_ctrl_out      ALU operation code (friscv_pkg ALU_*)
//   result_src_out    result select: 00 ALUOut, 01 mem data, 10 ALU result
//   illegal_instr_out one-cycle pulse for an unsupported instruction
//   err_out           sticky memory-timeout error
//   state_out         current state encoding, for debug
// -----------------------------------------------------------------------------
package friscv_pkg;

   // ALU operation codes
   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   // Supported opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECR    = 4'd7,
      S_EXECI    = 4'd8,
      S_ALUWB    = 4'd9,
      S_BEQ      = 4'd10,
      S_JAL      = 4'd11,
      S_TRAP     = 4'd12,
      S_ERROR    = 4'd13
   } state_t;

endpackage

module multicycle_controller
   import friscv_pkg::*;
#(
   parameter int ALU_CTRL_W  = 4,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [6:0]            op_code_in,
   input  logic [2:0]            func3_in,
   input  logic [6:0]            func7_in,
   input  logic                  zero_in,
   input  logic                  mem_ready_in,
   output logic                  mem_req_out,
   output logic                  mem_write_out,
   output logic                  adr_src_out,
   output logic                  ir_write_out,
   output logic                  pc_write_out,
   output logic                  reg_write_out,
   output logic [1:0]            alu_src_a_out,
   output logic [1:0]            alu_src_b_out,
   output logic [ALU_CTRL_W-1:0] alu_ctrl_out,
   output logic [1:0]            result_src_out,
   output logic                  illegal_instr_out,
   output logic                  err_out,
   output logic [3:0]            state_out
);

   // A zero-width counter is illegal, so keep at least one bit when the
   // timeout is disabled.
   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);

   state_t           state, state_next;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
   logic             mem_state;
   logic             timeout;
   logic [3:0]       alu_code;
   logic [3:0]       alu_sel;

   // Only func7[5] matters for RV32I; the remaining bits are ignored.
   logic unused_func7;
   assign unused_func7 = ^{func7_in[6], func7_in[4:0]};

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; combinational blocks below use blocking assignments.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state    <= S_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // ALU operation from func3/func7. SUB is R-type only (addi ignores
   // func7), whereas SRA is selected by func7[5] for both R- and I-type.
   always_comb begin
      alu_code = ALU_ADD;
      case (func3_in)
         3'b000:  alu_code = (state == S_EXECR && func7_in[5]) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_code = ALU_SLL;
         3'b010:  alu_code = ALU_SLT;
         3'b011:  alu_code = ALU_SLTU;
         3'b100:  alu_code = ALU_XOR;
         3'b101:  alu_code = func7_in[5] ? ALU_SRA : ALU_SRL;
         3'b110:  alu_code = ALU_OR;
         default: alu_code = ALU_AND;
      endcase
   end

   assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);

   // The limit cycle is the one where the counter already holds MEM_TIMEOUT;
   // a ready on that cycle takes the normal transition instead.
   assign timeout = (MEM_TIMEOUT != 0) && mem_state && !mem_ready_in && (wait_cnt == CNT_LIMIT);

   // NOTE: every output and next-state value gets a default before the case,
   // so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next        = state;
      mem_req_out       = 1'b0;
      mem_write_out     = 1'b0;
      adr_src_out       = 1'b0;
      ir_write_out      = 1'b0;
      pc_write_out      = 1'b0;
      reg_write_out     = 1'b0;
      alu_src_a_out     = 2'b00;
      alu_src_b_out     = 2'b00;
      alu_sel           = ALU_ADD;
      result_src_out    = 2'b00;
      illegal_instr_out = 1'b0;
      err_out           = 1'b0;

      case (state)
         S_IDLE: state_next = S_FETCH;
         S_FETCH: begin
            // PC+4 is computed and written in the same cycle the word arrives.
            mem_req_out    = 1'b1;
            alu_src_b_out  = 2'b10;
            result_src_out = 2'b10;
            ir_write_out   = mem_ready_in;
            pc_write_out   = mem_ready_in;
            if (mem_ready_in) state_next = S_DECODE;
         end
         S_DECODE: begin
            // ALU precomputes the branch target oldPC + imm into ALUOut.
            alu_src_a_out = 2'b01;
            alu_src_b_out = 2'b01;
            case (op_code_in)
               OP_LOAD, OP_STORE: state_next = (func3_in == 3'b010) ? S_MEMADR : S_TRAP;
               OP_RTYPE:          state_next = S_EXECR;
               OP_ITYPE:          state_next = S_EXECI;
               OP_BRANCH:         state_next = (func3_in == 3'b000) ? S_BEQ : S_TRAP;
               OP_JAL:            state_next = S_JAL;
               default:           state_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a_out = 2'b10;
            alu_src_b_out = 2'b01;
            state_next    = (op_code_in == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            mem_req_out = 1'b1;
            adr_src_out = 1'b1;
            if (mem_ready_in) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            result_src_out = 2'b01;
            reg_write_out  = 1'b1;
            state_next     = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req_out   = 1'b1;
            mem_write_out = 1'b1;
            adr_src_out   = 1'b1;
            if (mem_ready_in) state_next = S_FETCH;
         end
         S_EXECR: begin
            alu_src_a_out = 2'b10;
            alu_sel       = alu_code;
            state_next    = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a_out = 2'b10;
            alu_src_b_out = 2'b01;
            alu_sel       = alu_code;
            state_next    = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write_out = 1'b1;
            state_next    = S_FETCH;
         end
         S_BEQ: begin
            // The target from DECODE sits in ALUOut while the ALU compares.
            alu_src_a_out = 2'b10;
            alu_sel       = ALU_SUB;
            pc_write_out  = zero_in;
            state_next    = S_FETCH;
         end
         S_JAL: begin
            // PC <- ALUOut (target); ALU forms oldPC + 4 for the link in ALUWB.
            alu_src_a_out = 2'b01;
            alu_src_b_out = 2'b10;
            pc_write_out  = 1'b1;
            state_next    = S_ALUWB;
         end
         S_TRAP: begin
            illegal_instr_out = 1'b1;
            state_next        = S_FETCH;
         end
         S_ERROR: err_out = 1'b1;
         default: state_next = S_IDLE;
      endcase

      if (timeout) state_next = S_ERROR;
   end

   // The wait counter restarts whenever the memory side makes progress or the
   // FSM moves on.
   always_comb begin
      wait_cnt_next = '0;
      if (MEM_TIMEOUT != 0 && mem_state && !mem_ready_in && state_next == state)
         wait_cnt_next = wait_cnt + 1'b1;
   end

   assign alu_ctrl_out = ALU_CTRL_W'(alu_sel);
   assign state_out    = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller (MEM_TIMEOUT = 4). It applies a
// table of per-cycle {inputs, expected outputs} records. Expected output words
// are hand-assembled from the state output table. A hand-written sequence then
// covers the asynchronous reset in the middle of a store.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;
   import friscv_pkg::*;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic [6:0] op_code_in;
   logic [2:0] func3_in;
   logic [6:0] func7_in;
   logic       zero_in;
   logic       mem_ready_in;
   logic       mem_req_out, mem_write_out, adr_src_out, ir_write_out;
   logic       pc_write_out, reg_write_out, illegal_instr_out, err_out;
   logic [1:0] alu_src_a_out, alu_src_b_out, result_src_out;
   logic [3:0] alu_ctrl_out, state_out;

   always #5 clk_in = ~clk_in;

   multicycle_controller #(.ALU_CTRL_W(4), .MEM_TIMEOUT(4)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .op_code_in(op_code_in),
      .func3_in(func3_in), .func7_in(func7_in), .zero_in(zero_in),
      .mem_ready_in(mem_ready_in), .mem_req_out(mem_req_out),
      .mem_write_out(mem_write_out), .adr_src_out(adr_src_out),
      .ir_write_out(ir_write_out), .pc_write_out(pc_write_out),
      .reg_write_out(reg_write_out), .alu_src_a_out(alu_src_a_out),
      .alu_src_b_out(alu_src_b_out), .alu_ctrl_out(alu_ctrl_out),
      .result_src_out(result_src_out), .illegal_instr_out(illegal_instr_out),
      .err_out(err_out), .state_out(state_out)
   );

   // Output word: {req,wr,adr,irw,pcw,rw,a[1:0],b[1:0],alu[3:0],rs[1:0],ill,err,state[3:0]}
   typedef struct {
      bit          rst;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        zero;
      logic        rdy;
      logic [21:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   wire [21:0] act = {mem_req_out, mem_write_out, adr_src_out, ir_write_out,
                      pc_write_out, reg_write_out, alu_src_a_out, alu_src_b_out,
                      alu_ctrl_out, result_src_out, illegal_instr_out, err_out,
                      state_out};

   function automatic logic [21:0] o(logic [3:0] st, logic req, logic wr, logic adr,
                                     logic irw, logic pcw, logic rw, logic [1:0] a,
                                     logic [1:0] b, logic [3:0] alu, logic [1:0] rs,
                                     logic ill, logic err);
      return {req, wr, adr, irw, pcw, rw, a, b, alu, rs, ill, err, st};
   endfunction

   // Expected output words per state, written out from the state table.
   function automatic logic [21:0] e_idle();
      return o(S_IDLE, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ALU_ADD, 2'b00, 0, 0);
   endfunction
   function automatic logic [21:0] e_fetch(logic rdy);
      return o(S_FETCH, 1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, ALU_ADD, 2'b10, 0, 0);
   endfunction
   function automatic logic [21:0] e_decode();
      return o(S_DECODE, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, ALU_ADD, 2'b00, 0, 0);
   endfunction
   function automatic logic [21:0] e_memadr();
      return o(S_MEMADR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, ALU_ADD, 2'b00, 0, 0);
   endfunction
   function automatic logic [21:0] e_memread();
      return o(S_MEMREAD, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, ALU_ADD, 2'b00, 0, 0);
   endfunction
   function automatic logic [21:0] e_memwb();
      return o(S_MEMWB, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ALU_ADD, 2'b01, 0, 0);
   endfunction
   function automatic logic [21:0] e_memwrite();
      return o(S_MEMWRITE, 1, 1, 1, 0, 0, 0, 2'b00, 2'b00, ALU_ADD, 2'b00, 0, 0);
   endfunction
   function automatic logic [21:0] e_execr(logic [3:0] alu);
      return o(S_EXECR, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, alu, 2'b00, 0, 0);
   endfunction
   function automatic logic [21:0] e_execi(logic [3:0] alu);
      return o(S_EXECI, 0, 0, 0, 0, 0, 0, 2'b10, 2'b01, alu, 2'b00, 0, 0);
   endfunction
   function automatic logic [21:0] e_aluwb();
      return o(S_ALUWB, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, ALU_ADD, 2'b00, 0, 0);
   endfunction
   function automatic logic [21:0] e_beq(logic z);
      return o(S_BEQ, 0, 0, 0, 0, z, 0, 2'b10, 2'b00, ALU_SUB, 2'b00, 0, 0);
   endfunction
   function automatic logic [21:0] e_jal();
      return o(S_JAL, 0, 0, 0, 0, 1, 0, 2'b01, 2'b10, ALU_ADD, 2'b00, 0, 0);
   endfunction
   function automatic logic [21:0] e_trap();
      return o(S_TRAP, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ALU_ADD, 2'b00, 1, 0);
   endfunction
   function automatic logic [21:0] e_error();
      return o(S_ERROR, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, ALU_ADD, 2'b00, 0, 1);
   endfunction

   task automatic check(string name, logic [21:0] got, logic [21:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (state got %0d expected %0d)",
                  name, got, exp, got[3:0], exp[3:0]);
      end
   endtask

   task automatic push(bit r, logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                       logic z, logic rdy, logic [21:0] e, string n);
      vecs.push_back('{r, op, f3, f7, z, rdy, e, n});
   endtask

   // Zero-wait arithmetic instruction: FETCH, DECODE, EXECR/EXECI, ALUWB.
   task automatic arith(logic [6:0] op, logic [2:0] f3, logic [6:0] f7,
                        logic [3:0] alu, string n);
      push(0, op, f3, f7, 0, 1, e_fetch(1), {n, "_fetch"});
      push(0, op, f3, f7, 0, 1, e_decode(), {n, "_decode"});
      push(0, op, f3, f7, 0, 1, (op == OP_RTYPE) ? e_execr(alu) : e_execi(alu), {n, "_exec"});
      push(0, op, f3, f7, 0, 1, e_aluwb(), {n, "_aluwb"});
   endtask

   initial begin
      rst_in = 1'b1; op_code_in = '0; func3_in = '0; func7_in = '0;
      zero_in = 1'b0; mem_ready_in = 1'b0;

      // ---- table: arithmetic decode --------------------------------------
      push(1, OP_RTYPE, 3'b000, 7'h00, 0, 1, e_idle(), "reset_idle");
      arith(OP_RTYPE, 3'b000, 7'b0000000, ALU_ADD,  "add");
      arith(OP_RTYPE, 3'b000, 7'b0100000, ALU_SUB,  "sub");
      arith(OP_RTYPE, 3'b001, 7'b0000000, ALU_SLL,  "sll");
      arith(OP_RTYPE, 3'b011, 7'b0000000, ALU_SLTU, "sltu");
      arith(OP_RTYPE, 3'b101, 7'b0100000, ALU_SRA,  "sra");
      arith(OP_RTYPE, 3'b111, 7'b0000000, ALU_AND,  "and");
      arith(OP_ITYPE, 3'b000, 7'b0100000, ALU_ADD,  "addi_f7set");
      arith(OP_ITYPE, 3'b001, 7'b0000000, ALU_SLL,  "slli");
      arith(OP_ITYPE, 3'b010, 7'b0000000, ALU_SLT,  "slti");
      arith(OP_ITYPE, 3'b011, 7'b0000000, ALU_SLTU, "sltiu");
      arith(OP_ITYPE, 3'b100, 7'b0000000, ALU_XOR,  "xori");
      arith(OP_ITYPE, 3'b101, 7'b0000000, ALU_SRL,  "srli");
      arith(OP_ITYPE, 3'b101, 7'b0100000, ALU_SRA,  "srai");
      arith(OP_ITYPE, 3'b110, 7'b0000000, ALU_OR,   "ori");
      arith(OP_ITYPE, 3'b111, 7'b0000000, ALU_AND,  "andi");

      // ---- zero-wait lw (5 cycles) and sw (4 cycles) ----------------------
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_fetch(1),   "lw_fetch");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_decode(),   "lw_decode");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_memadr(),   "lw_memadr");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_memread(),  "lw_memread");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_memwb(),    "lw_memwb");
      push(0, OP_STORE, 3'b010, 0, 0, 1, e_fetch(1),  "sw_fetch");
      push(0, OP_STORE, 3'b010, 0, 0, 1, e_decode(),  "sw_decode");
      push(0, OP_STORE, 3'b010, 0, 0, 1, e_memadr(),  "sw_memadr");
      push(0, OP_STORE, 3'b010, 0, 0, 1, e_memwrite(), "sw_memwrite");

      // ---- lw with 3 wait cycles in MEMREAD: mem_req held 4 cycles ---------
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_fetch(1),  "lww_fetch");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_decode(),  "lww_decode");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_memadr(),  "lww_memadr");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_memread(), "lww_wait1");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_memread(), "lww_wait2");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_memread(), "lww_wait3");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_memread(), "lww_ready");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_memwb(),   "lww_memwb");

      // ---- beq taken / not taken, jal -------------------------------------
      push(0, OP_BRANCH, 3'b000, 0, 1, 1, e_fetch(1), "beqt_fetch");
      push(0, OP_BRANCH, 3'b000, 0, 1, 1, e_decode(), "beqt_decode");
      push(0, OP_BRANCH, 3'b000, 0, 1, 1, e_beq(1),   "beq_taken");
      push(0, OP_BRANCH, 3'b000, 0, 0, 1, e_fetch(1), "beqn_fetch");
      push(0, OP_BRANCH, 3'b000, 0, 0, 1, e_decode(), "beqn_decode");
      push(0, OP_BRANCH, 3'b000, 0, 0, 1, e_beq(0),   "beq_not_taken");
      push(0, OP_JAL, 3'b000, 0, 0, 1, e_fetch(1),    "jal_fetch");
      push(0, OP_JAL, 3'b000, 0, 0, 1, e_decode(),    "jal_decode");
      push(0, OP_JAL, 3'b000, 0, 0, 1, e_jal(),       "jal_jal");
      push(0, OP_JAL, 3'b000, 0, 0, 1, e_aluwb(),     "jal_aluwb");

      // ---- illegal encodings -> TRAP pulse, back to FETCH -----------------
      push(0, 7'b1111111, 3'b000, 0, 0, 1, e_fetch(1), "ill_fetch");
      push(0, 7'b1111111, 3'b000, 0, 0, 1, e_decode(), "ill_decode");
      push(0, 7'b1111111, 3'b000, 0, 0, 1, e_trap(),   "ill_trap");
      push(0, OP_LOAD, 3'b001, 0, 0, 1, e_fetch(1),    "lwf3_fetch");
      push(0, OP_LOAD, 3'b001, 0, 0, 1, e_decode(),    "lwf3_decode");
      push(0, OP_LOAD, 3'b001, 0, 0, 1, e_trap(),      "lwf3_trap");
      push(0, OP_BRANCH, 3'b001, 0, 0, 1, e_fetch(1),  "bne_fetch");
      push(0, OP_BRANCH, 3'b001, 0, 0, 1, e_decode(),  "bne_decode");
      push(0, OP_BRANCH, 3'b001, 0, 0, 1, e_trap(),    "bne_trap");
      push(0, OP_RTYPE, 3'b000, 0, 0, 1, e_fetch(1),   "after_trap_fetch");

      // ---- timeout: 4 tolerated waits, 5th not-ready cycle -> ERROR ---------
      push(1, OP_RTYPE, 3'b000, 0, 0, 0, e_idle(),   "to_reset");
      push(0, OP_RTYPE, 3'b000, 0, 0, 0, e_fetch(0), "to_wait0");
      push(0, OP_RTYPE, 3'b000, 0, 0, 0, e_fetch(0), "to_wait1");
      push(0, OP_RTYPE, 3'b000, 0, 0, 0, e_fetch(0), "to_wait2");
      push(0, OP_RTYPE, 3'b000, 0, 0, 0, e_fetch(0), "to_wait3");
      push(0, OP_RTYPE, 3'b000, 0, 0, 0, e_fetch(0), "to_limit");
      push(0, OP_RTYPE, 3'b000, 0, 0, 1, e_error(),  "to_error");
      push(0, OP_RTYPE, 3'b000, 0, 0, 1, e_error(),  "to_error_sticky");
      push(1, OP_LOAD, 3'b010, 0, 0, 0, e_idle(),    "to_reset_clears");

      // ---- ready exactly on the limit cycle (FETCH, then MEMREAD) ----------
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_fetch(0),  "lim_f_wait0");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_fetch(0),  "lim_f_wait1");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_fetch(0),  "lim_f_wait2");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_fetch(0),  "lim_f_wait3");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_fetch(1),  "lim_f_ready");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_decode(),  "lim_decode");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_memadr(),  "lim_memadr");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_memread(), "lim_r_wait0");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_memread(), "lim_r_wait1");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_memread(), "lim_r_wait2");
      push(0, OP_LOAD, 3'b010, 0, 0, 0, e_memread(), "lim_r_wait3");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_memread(), "lim_r_ready");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_memwb(),   "lim_memwb");
      push(0, OP_LOAD, 3'b010, 0, 0, 1, e_fetch(1),  "lim_refetch");

      // Apply on the falling edge, compare 1 ns later, well away from posedge.
      @(negedge clk_in);
      foreach (vecs[i]) begin
         if (vecs[i].rst) begin
            rst_in = 1'b1;
            @(negedge clk_in);
            rst_in = 1'b0;
         end
         op_code_in   = vecs[i].op;
         func3_in     = vecs[i].f3;
         func7_in     = vecs[i].f7;
         zero_in      = vecs[i].zero;
         mem_ready_in = vecs[i].rdy;
         #1;
         check(vecs[i].name, act, vecs[i].exp);
         @(negedge clk_in);
      end

      // ---- asynchronous reset in the middle of a store --------------------
      rst_in = 1'b1;
      op_code_in = OP_STORE; func3_in = 3'b010; func7_in = '0; mem_ready_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b0;
      #1 check("sw_async_idle", act, e_idle());
      @(negedge clk_in);
      #1 check("sw_async_fetch", act, e_fetch(1));
      @(negedge clk_in);
      mem_ready_in = 1'b0;
      #1 check("sw_async_decode", act, e_decode());
      @(negedge clk_in);
      #1 check("sw_async_memadr", act, e_memadr());
      @(negedge clk_in);
      #1 check("sw_async_memwrite", act, e_memwrite());
      #2 rst_in = 1'b1;
      #1 check("async_rst_midwrite", act, e_idle());
      @(negedge clk_in);
      rst_in = 1'b0;
      mem_ready_in = 1'b1;
      #1 check("after_async_idle", act, e_idle());
      @(negedge clk_in);
      #1 check("after_async_fetch", act, e_fetch(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
